mac_accum: RTL and testbench
============================

MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, operand width in signed fixed point.
REQ-002 SHALL have parameter FRAC_WIDTH, default 8, fractional bits per operand; the module carries it but its arithmetic does not use it.
REQ-003 SHALL have parameter DEPTH, default 4, products per dot product; legal range is DEPTH >= 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operand pair valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts an operand pair.
REQ-008 SHALL have port in_a, input, BIT_WIDTH bits: signed operand A.
REQ-009 SHALL have port in_b, input, BIT_WIDTH bits: signed operand B.
REQ-010 SHALL have port out_valid, output, 1 bit: accumulated result valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream saturation stage accepts the result.
REQ-012 SHALL have port out_acc, output, 2*BIT_WIDTH bits: signed raw sum with 2*FRAC_WIDTH fractional bits, ready for narrowing downstream.

Function
REQ-013 SHALL form each product as the full-width signed in_a*in_b, 2*BIT_WIDTH bits, with no rounding or truncation.
REQ-014 SHALL accumulate modulo 2^(2*BIT_WIDTH), two's complement wrap; overflow is neither flagged nor saturated here.
REQ-015 SHALL use a two-state FSM: ACC (accepting operands) and OUT (result held).
REQ-016 SHALL define a beat as a rising edge with in_valid && in_ready; only beats change the accumulator or the beat counter.
REQ-017 SHALL keep a beat counter cnt, 0..DEPTH-1; in ACC, a beat with cnt==0 loads acc with the product, and any other beat adds the product to acc.
REQ-018 SHALL increment cnt on each beat with cnt < DEPTH-1; a beat with cnt==DEPTH-1 sets cnt to 0, writes the final sum to out_acc, and moves the FSM to OUT.
REQ-019 SHALL drive out_valid=1 exactly while the FSM is in OUT; the first valid cycle is the cycle after the DEPTH-th beat.
REQ-020 SHALL hold out_acc and out_valid stable in OUT until out_ready=1.
REQ-021 SHALL drive in_ready = (state==ACC) || (state==OUT && out_ready), combinationally from out_ready.
REQ-022 SHALL handle an out_ready=1 cycle in OUT as follows: the result is consumed; with a beat, that beat is the first product (cnt==0 load) of the next dot product, FSM goes to ACC, cnt=1; without a beat, FSM goes to ACC, cnt=0.
REQ-023 SHALL ignore in_valid, in_a and in_b in OUT while out_ready=0.
REQ-024 SHALL make a beat on DEPTH-th operand and out_ready in the same cycle impossible, since in_ready=1 in ACC does not depend on out_ready.
REQ-025 SHALL give a latency of one cycle from the DEPTH-th beat to out_valid, and sustain one result per DEPTH cycles under continuous valid/ready.
REQ-026 SHALL update out_acc only on the transition into OUT; out_acc holds its value in ACC and is not qualified there.

Reset
REQ-027 SHALL, on clk edge with rst=1, set FSM=ACC, cnt=0, acc=0, out_acc=0 and out_valid=0; in_ready is 1 during the next cycle.
REQ-028 SHALL discard any partial sum and any pending result on a reset taken mid-operation; no out_valid pulse follows.
REQ-029 SHALL give rst priority over a beat and over an out_ready in the same cycle.

Verification
REQ-030 SHALL cover: DEPTH=4, in_a=0x0100, in_b=0x0200 for four beats, out_ready=1 -> out_valid one cycle after the 4th beat, out_acc=0x00080000.
REQ-031 SHALL cover: in_a=0xFF00, in_b=0x0100 for four beats -> out_acc=0xFFFC0000.
REQ-032 SHALL cover wrap-around: in_a=in_b=0x8000 for four beats -> out_acc=0x00000000, no flag raised.
REQ-033 SHALL cover backpressure: out_ready=0 for 3 cycles in OUT with in_valid=1 and changing operands -> in_ready=0, out_acc constant; the next sum is unaffected by the ignored operands.
REQ-034 SHALL cover back-to-back: in_valid=1 and out_ready=1 continuously, two dot products -> results 0x00080000 then 0x00040000 (second set in_b=0x0100); the first beat of set 2 is accepted in the OUT cycle.
REQ-035 SHALL cover reset mid-operation: rst=1 after 2 beats -> out_valid=0, then four fresh beats of 0x0100*0x0100 -> out_acc=0x00040000.

Source files
------------

// File: rtl/mac_accum.sv
// Multiply-accumulate over DEPTH signed operand pairs, then hold the raw full-width
// sum for a downstream saturation stage under valid/ready handshaking.
module mac_accum #(
    parameter int BIT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BIT_WIDTH-1:0]       in_a,
    input  logic [BIT_WIDTH-1:0]       in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*BIT_WIDTH-1:0]     out_acc
);

    localparam int AW = 2 * BIT_WIDTH;
    localparam int CW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    // Elaboration-time guard on the parameter set.
    if (DEPTH < 2 || FRAC_WIDTH < 0 || FRAC_WIDTH > BIT_WIDTH) begin : g_param_check
        $error("mac_accum: illegal parameters");
    end

    typedef enum logic {ACC = 1'b0, OUT = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] out_acc_q, out_acc_d;

    logic signed [AW-1:0] prod;
    logic signed [AW-1:0] sum;
    logic                 beat;

    // Sign-extend to full width first; the low AW bits of the product are exact.
    assign prod = $signed({{BIT_WIDTH{in_a[BIT_WIDTH-1]}}, in_a})
                * $signed({{BIT_WIDTH{in_b[BIT_WIDTH-1]}}, in_b});
    assign sum  = (cnt_q == '0) ? prod : acc_q + prod;

    assign in_ready  = (state_q == ACC) || (state_q == OUT && out_ready);
    assign beat      = in_valid && in_ready;
    assign out_valid = (state_q == OUT);
    assign out_acc   = out_acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        out_acc_d = out_acc_q;
        case (state_q)
            ACC: begin
                if (beat) begin
                    acc_d = sum;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        out_acc_d = sum;
                        state_d   = OUT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            OUT: begin
                // Consuming the result frees the slot; a beat here starts the next set.
                if (out_ready) begin
                    state_d = ACC;
                    if (beat) begin
                        acc_d = prod;
                        cnt_d = CW'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACC;
            cnt_q     <= '0;
            acc_q     <= '0;
            out_acc_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            out_acc_q <= out_acc_d;
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum at BIT_WIDTH=16, DEPTH=4 with hand-computed sums.
module tb_mac_accum;

    localparam int BIT_WIDTH = 16;
    localparam int DEPTH     = 4;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [BIT_WIDTH-1:0]   in_a;
    logic [BIT_WIDTH-1:0]   in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*BIT_WIDTH-1:0] out_acc;

    int n_checks = 0;
    int n_errors = 0;

    mac_accum #(.BIT_WIDTH(BIT_WIDTH), .FRAC_WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n beats of one operand pair, checking out_valid stays low until the last.
    task automatic beats(input int n, input logic [15:0] a, input logic [15:0] b, input string tag);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i < n - 1) chk({tag, "_busy"}, 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_acc",   64'(out_acc),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // Basic positive dot product.
        beats(DEPTH, 16'h0100, 16'h0200, "pos");
        in_valid = 1'b0;
        chk("pos_valid", 64'(out_valid), 64'd1);
        chk("pos_acc",   64'(out_acc),   64'h0008_0000);
        tick();
        chk("pos_consumed", 64'(out_valid), 64'd0);
        chk("pos_hold_acc", 64'(out_acc),   64'h0008_0000);

        // Negative operand.
        beats(DEPTH, 16'hFF00, 16'h0100, "neg");
        in_valid = 1'b0;
        chk("neg_valid", 64'(out_valid), 64'd1);
        chk("neg_acc",   64'(out_acc),   64'hFFFC_0000);
        tick();

        // Wrap-around: 4 * 2^30 = 2^32 wraps to zero.
        beats(DEPTH, 16'h8000, 16'h8000, "wrap");
        in_valid = 1'b0;
        chk("wrap_valid", 64'(out_valid), 64'd1);
        chk("wrap_acc",   64'(out_acc),   64'h0000_0000);
        tick();

        // Backpressure: result holds, operands offered in OUT are ignored.
        out_ready = 1'b0;
        beats(DEPTH, 16'h0100, 16'h0200, "bp");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 16'h1234 + 16'(i);
            in_b     = 16'h7F00 - 16'(i);
            #1;
            chk("bp_in_ready", 64'(in_ready),  64'd0);
            chk("bp_valid",    64'(out_valid), 64'd1);
            chk("bp_acc",      64'(out_acc),   64'h0008_0000);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_released", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        beats(DEPTH, 16'h0100, 16'h0100, "bp2");
        chk("bp2_valid", 64'(out_valid), 64'd1);
        chk("bp2_acc",   64'(out_acc),   64'h0004_0000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();

        // Back-to-back: first beat of set 2 lands in the OUT cycle.
        beats(DEPTH, 16'h0100, 16'h0200, "b2b1");
        chk("b2b1_valid", 64'(out_valid), 64'd1);
        chk("b2b1_acc",   64'(out_acc),   64'h0008_0000);
        in_b = 16'h0100;
        #1;
        chk("b2b_in_ready_out", 64'(in_ready), 64'd1);
        beats(DEPTH, 16'h0100, 16'h0100, "b2b2");
        chk("b2b2_valid", 64'(out_valid), 64'd1);
        chk("b2b2_acc",   64'(out_acc),   64'h0004_0000);
        in_valid = 1'b0;
        tick();

        // Reset mid-accumulation with a beat offered in the same cycle.
        beats(2, 16'h0100, 16'h0200, "mid");
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_acc",   64'(out_acc),   64'd0);
        tick();
        chk("mid_rst_nopulse", 64'(out_valid), 64'd0);
        beats(DEPTH, 16'h0100, 16'h0100, "fresh");
        in_valid = 1'b0;
        chk("fresh_valid", 64'(out_valid), 64'd1);
        chk("fresh_acc",   64'(out_acc),   64'h0004_0000);

        // Reset while a result is pending and out_ready is asserted.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("pend_rst_valid",    64'(out_valid), 64'd0);
        chk("pend_rst_in_ready", 64'(in_ready),  64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
